// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU (AND/OR/ADD/SUB/SLT): one 1-bit slice, LSB first, WIDTH RUN cycles then a one-cycle done.
// start is sampled only in IDLE; requests arriving while busy or done are dropped.
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bEff;
  logic [2:0]       opReg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] shReg;

  logic             aBit;
  logic             bBit;
  logic             sumBit;
  logic             carryNext;
  logic             sliceOut;
  logic             isArith;
  logic             isSlt;
  logic             subLike;
  logic [WIDTH-1:0] shiftNext;
  logic [WIDTH-1:0] finalResult;

  // The 1-bit slice; on the last bit, carry is the carry into the MSB.
  always_comb begin
    aBit      = aReg[cnt];
    bBit      = bEff[cnt];
    sumBit    = aBit ^ bBit ^ carry;
    carryNext = (aBit & bBit) | (carry & (aBit ^ bBit));
    isArith   = (opReg == OpAdd) || (opReg == OpSub);
    isSlt     = (opReg == OpSlt);
    subLike   = (op == OpSub) || (op == OpSlt);
    sliceOut  = 1'b0;
    case (opReg)
      OpAnd:               sliceOut = aBit & bBit;
      OpOr:                sliceOut = aBit | bBit;
      OpAdd, OpSub, OpSlt: sliceOut = sumBit;
      default:             sliceOut = 1'b0;
    endcase
    shiftNext = {sliceOut, shReg[WIDTH-1:1]};
    // SLT: less-than is sign(a-b) XOR signed overflow of a-b.
    if (isSlt)
      finalResult = {{(WIDTH-1){1'b0}}, sumBit ^ (carry ^ carryNext)};
    else
      finalResult = shiftNext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      cnt       <= '0;
      carry     <= 1'b0;
      aReg      <= '0;
      bEff      <= '0;
      opReg     <= OpAnd;
      shReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg  <= a;
            opReg <= op;
            bEff  <= subLike ? ~b : b;
            carry <= subLike;
            cnt   <= '0;
            shReg <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          shReg <= shiftNext;
          carry <= carryNext;
          if (cnt == LastBit) begin
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= finalResult;
            carry_out <= isArith & carryNext;
            overflow  <= isArith & (carry ^ carryNext);
            zero      <= (finalResult == '0);
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl at WIDTH=32 with hand-computed expectations.
module tb_serial_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCnt;
  int doneEdge;

  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Entered #1 after an edge with the DUT idle; leaves it idle again.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    int lat;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op = o ^ 3'b001;
    checkEq({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkEq({tag, ".latency"}, 32'(lat), 32'd32);
    checkEq({tag, ".result"}, result, er);
    checkEq({tag, ".carry"}, 32'(carry_out), 32'(ec));
    checkEq({tag, ".ovf"}, 32'(overflow), 32'(ev));
    checkEq({tag, ".zero"}, 32'(zero), 32'(ez));
    @(posedge clk); #1;
    checkEq({tag, ".doneDrop"}, 32'(done), 32'd0);
    checkEq({tag, ".hold"}, result, er);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst.busy", 32'(busy), 32'd0);
    checkEq("rst.done", 32'(done), 32'd0);
    checkEq("rst.result", result, 32'd0);
    checkEq("rst.carry", 32'(carry_out), 32'd0);
    checkEq("rst.ovf", 32'(overflow), 32'd0);
    checkEq("rst.zero", 32'(zero), 32'd1);
    rst_n = 1'b1;

    runOp("addWrap", 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    runOp("addOvf",  3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
    runOp("subNeg",  3'b011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    runOp("subPos",  3'b011, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0);
    runOp("subZero", 3'b011, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b1);
    runOp("slt1",    3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    runOp("slt2",    3'b100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);
    runOp("slt3",    3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    runOp("and",     3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    runOp("or",      3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    runOp("rsvd",    3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Starts presented during RUN (edges 5 and 32) must be dropped.
    start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    doneCnt = 0; doneEdge = 0;
    for (int e = 1; e <= 33; e++) begin
      if (e == 5 || e == 32) begin
        start = 1'b1; op = 3'b011; a = 32'hDEAD0000; b = 32'h00001111;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        doneCnt++;
        doneEdge = e;
      end
    end
    checkEq("ign.doneCnt", 32'(doneCnt), 32'd1);
    checkEq("ign.doneEdge", 32'(doneEdge), 32'd32);
    checkEq("ign.result", result, 32'd3);
    checkEq("ign.idleBusy", 32'(busy), 32'd0);
    runOp("ign.next", 3'b010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);

    // Reset at edge 10 of a SUB abandons it without a done pulse.
    start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkEq("rstMid.busy", 32'(busy), 32'd0);
    checkEq("rstMid.result", result, 32'd0);
    checkEq("rstMid.zero", 32'(zero), 32'd1);
    checkEq("rstMid.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkEq("rstMid.noDone", 32'(doneCnt), 32'd0);
    runOp("rstMid.add", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
